load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 44 ++++
 rtl/load_align.sv | 36 +++
 rtl/load_store_unit.sv | 148 ++++++++++++++
 tb/tb_load_store_unit.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states,
// lane offsets and request legality helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } lsu_state_e;

    // Byte offsets within a big-endian word; offset 0 is the most significant lane.
    localparam logic [1:0] BYTE_OFF_0  = 2'd0;
    localparam logic [1:0] BYTE_OFF_1  = 2'd1;
    localparam logic [1:0] BYTE_OFF_2  = 2'd2;
    localparam logic [1:0] BYTE_OFF_3  = 2'd3;
    localparam logic [1:0] HALF_OFF_HI = 2'd0;
    localparam logic [1:0] HALF_OFF_LO = 2'd2;

    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        if ((f3 == F3_H) || (f3 == F3_HU)) begin
            return off[0];
        end
        if (f3 == F3_W) begin
            return off != 2'd0;
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational lane select and sign/zero extension of a big-endian memory
// word for RV32I loads.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = word_i[7:0];
        unique case (offset_i)
            BYTE_OFF_0: byte_lane = word_i[31:24];
            BYTE_OFF_1: byte_lane = word_i[23:16];
            BYTE_OFF_2: byte_lane = word_i[15:8];
            BYTE_OFF_3: byte_lane = word_i[7:0];
        endcase

        half_lane = (offset_i == HALF_OFF_LO) ? word_i[15:0] : word_i[31:16];

        data_o = word_i;
        case (funct3_i)
            F3_B:    data_o = {{24{byte_lane[7]}}, byte_lane};
            F3_BU:   data_o = {24'd0, byte_lane};
            F3_H:    data_o = {{16{half_lane[15]}}, half_lane};
            F3_HU:   data_o = {16'd0, half_lane};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-request load/store unit between a CPU and a word-wide data memory;
// sub-word stores are done as read-modify-write of the addressed word.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_we_i,
    input  logic [2:0]               req_funct3_i,
    input  logic [ADDRESS_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0]    req_wdata_i,
    output logic                     resp_valid_o,
    output logic [DATA_WIDTH-1:0]    resp_rdata_o,
    output logic                     resp_error_o,
    output logic [ADDRESS_WIDTH-1:0] mem_address_o,
    output logic                     mem_write_enable_o,
    output logic [DATA_WIDTH-1:0]    mem_write_data_o,
    input  logic [DATA_WIDTH-1:0]    mem_read_value_i
);

    lsu_state_e               state_q, state_d;
    logic                     we_q, we_d;
    logic [2:0]               funct3_q, funct3_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic                     err_q, err_d;
    logic [DATA_WIDTH-1:0]    rword_q, rword_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;

    logic                     req_err;
    logic [DATA_WIDTH-1:0]    load_data;
    logic [DATA_WIDTH-1:0]    merged_word;

    assign req_err = !funct3_legal(req_we_i, req_funct3_i) ||
                     misaligned(req_funct3_i, req_addr_i[1:0]);

    load_align u_load_align (
        .word_i   (mem_read_value_i),
        .funct3_i (funct3_q),
        .offset_i (addr_q[1:0]),
        .data_o   (load_data)
    );

    // Replace only the addressed lane of the word captured during READ.
    always_comb begin
        merged_word = rword_q;
        if (funct3_q == F3_H) begin
            if (addr_q[1:0] == HALF_OFF_LO) begin
                merged_word[15:0] = wdata_q[15:0];
            end else begin
                merged_word[31:16] = wdata_q[15:0];
            end
        end else begin
            unique case (addr_q[1:0])
                BYTE_OFF_0: merged_word[31:24] = wdata_q[7:0];
                BYTE_OFF_1: merged_word[23:16] = wdata_q[7:0];
                BYTE_OFF_2: merged_word[15:8]  = wdata_q[7:0];
                BYTE_OFF_3: merged_word[7:0]   = wdata_q[7:0];
            endcase
        end
    end

    always_comb begin
        state_d            = state_q;
        we_d               = we_q;
        funct3_d           = funct3_q;
        addr_d             = addr_q;
        wdata_d            = wdata_q;
        err_d              = err_q;
        rword_d            = rword_q;
        rdata_d            = rdata_q;
        req_ready_o        = 1'b0;
        resp_valid_o       = 1'b0;
        mem_write_enable_o = 1'b0;
        mem_write_data_o   = '0;

        unique case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    we_d     = req_we_i;
                    funct3_d = req_funct3_i;
                    addr_d   = req_addr_i;
                    wdata_d  = req_wdata_i;
                    err_d    = req_err;
                    rdata_d  = '0;
                    if (req_err) begin
                        state_d = ST_RESP;
                    end else if (req_we_i && (req_funct3_i == F3_W)) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (we_q) begin
                    rword_d = mem_read_value_i;
                    state_d = ST_WRITE;
                end else begin
                    rdata_d = load_data;
                    state_d = ST_RESP;
                end
            end
            ST_WRITE: begin
                mem_write_enable_o = 1'b1;
                mem_write_data_o   = (funct3_q == F3_W) ? wdata_q : merged_word;
                state_d            = ST_RESP;
            end
            ST_RESP: begin
                resp_valid_o = 1'b1;
                state_d      = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            rword_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            rword_q  <= rword_d;
            rdata_q  <= rdata_d;
        end
    end

    assign resp_rdata_o  = rdata_q;
    assign resp_error_o  = (state_q == ST_RESP) && err_q;
    assign mem_address_o = {addr_q[ADDRESS_WIDTH-1:2], 2'b00};

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a small word-addressed memory
// model; one line printed per transaction.
module tb_load_store_unit;

    logic        clk_i;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_error_o;
    logic [31:0] mem_address_o;
    logic        mem_write_enable_o;
    logic [31:0] mem_write_data_o;
    logic [31:0] mem_read_value_i;

    logic [31:0] mem [256];
    int          wr_count = 0;
    logic [31:0] last_wr_addr = 32'd0;
    logic [31:0] last_wr_data = 32'd0;

    int n_cmp  = 0;
    int n_fail = 0;

    load_store_unit #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32)
    ) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .req_valid_i        (req_valid_i),
        .req_ready_o        (req_ready_o),
        .req_we_i           (req_we_i),
        .req_funct3_i       (req_funct3_i),
        .req_addr_i         (req_addr_i),
        .req_wdata_i        (req_wdata_i),
        .resp_valid_o       (resp_valid_o),
        .resp_rdata_o       (resp_rdata_o),
        .resp_error_o       (resp_error_o),
        .mem_address_o      (mem_address_o),
        .mem_write_enable_o (mem_write_enable_o),
        .mem_write_data_o   (mem_write_data_o),
        .mem_read_value_i   (mem_read_value_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    assign mem_read_value_i = mem[mem_address_o[9:2]];

    always @(posedge clk_i) begin
        if (mem_write_enable_o) begin
            mem[mem_address_o[9:2]] <= mem_write_data_o;
            wr_count     <= wr_count + 1;
            last_wr_addr <= mem_address_o;
            last_wr_data <= mem_write_data_o;
        end
    end

    // Drives one request, waits (bounded) for the response pulse and samples
    // resp_valid_o one cycle later. lat = -1 means no response arrived.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output int lat, output logic [31:0] rdata,
                         output logic err, output logic vld_after);
        @(negedge clk_i);
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_funct3_i = f3;
        req_addr_i   = addr;
        req_wdata_i  = wd;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        lat   = -1;
        rdata = 32'd0;
        err   = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk_i);
            if (resp_valid_o) begin
                lat   = c;
                rdata = resp_rdata_o;
                err   = resp_error_o;
                break;
            end
        end
        @(negedge clk_i);
        vld_after = resp_valid_o;
        $display("txn we=%0b f3=%03b addr=%08h wdata=%08h -> lat=%0d rdata=%08h err=%0b",
                 we, f3, addr, wd, lat, rdata, err);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        n_cmp++;
        if ({resp_valid_o, resp_error_o, mem_write_enable_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got valid/err/we=%03b want 000",
                     {resp_valid_o, resp_error_o, mem_write_enable_o});
        end
        n_cmp++;
        if (resp_rdata_o !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %08h want 00000000", resp_rdata_o);
        end
        n_cmp++;
        if ({mem_address_o, mem_write_data_o} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_mem: got addr=%08h wdata=%08h want 0/0",
                     mem_address_o, mem_write_data_o);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
        n_cmp++;
        if (req_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %0b want 1", req_ready_o);
        end
    endtask

    task automatic test_loads();
        int lat;
        logic [31:0] rd;
        logic err, va;
        int wc;
        wc = wr_count;
        issue(1'b0, 3'b000, 32'h100, 32'd0, lat, rd, err, va);
        n_cmp++;
        if (rd !== 32'hFFFFFF80 || lat != 2 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL lb_100: got rdata=%08h lat=%0d err=%0b want FFFFFF80 2 0", rd, lat, err);
        end
        n_cmp++;
        if (va !== 1'b0) begin
            n_fail++;
            $display("FAIL resp_pulse: got valid=%0b one cycle later want 0", va);
        end
        issue(1'b0, 3'b100, 32'h103, 32'd0, lat, rd, err, va);
        n_cmp++;
        if (rd !== 32'h00000001 || lat != 2) begin
            n_fail++;
            $display("FAIL lbu_103: got rdata=%08h lat=%0d want 00000001 2", rd, lat);
        end
        issue(1'b0, 3'b101, 32'h102, 32'd0, lat, rd, err, va);
        n_cmp++;
        if (rd !== 32'h00007F01 || lat != 2) begin
            n_fail++;
            $display("FAIL lhu_102: got rdata=%08h lat=%0d want 00007F01 2", rd, lat);
        end
        issue(1'b0, 3'b001, 32'h100, 32'd0, lat, rd, err, va);
        n_cmp++;
        if (rd !== 32'hFFFF80FF || lat != 2) begin
            n_fail++;
            $display("FAIL lh_100: got rdata=%08h lat=%0d want FFFF80FF 2", rd, lat);
        end
        n_cmp++;
        if (wr_count != wc) begin
            n_fail++;
            $display("FAIL loads_no_write: got %0d writes want 0", wr_count - wc);
        end
    endtask

    task automatic test_store_byte();
        int lat, wc;
        logic [31:0] rd;
        logic err, va;
        wc = wr_count;
        issue(1'b1, 3'b000, 32'h101, 32'h123456AA, lat, rd, err, va);
        n_cmp++;
        if (lat != 3 || err !== 1'b0 || rd !== 32'd0) begin
            n_fail++;
            $display("FAIL sb_resp: got lat=%0d err=%0b rdata=%08h want 3 0 00000000", lat, err, rd);
        end
        n_cmp++;
        if (wr_count != wc + 1 || last_wr_addr !== 32'h100 || last_wr_data !== 32'h80AA7F01) begin
            n_fail++;
            $display("FAIL sb_write: got n=%0d addr=%08h data=%08h want 1 00000100 80AA7F01",
                     wr_count - wc, last_wr_addr, last_wr_data);
        end
        issue(1'b0, 3'b010, 32'h100, 32'd0, lat, rd, err, va);
        n_cmp++;
        if (rd !== 32'h80AA7F01 || lat != 2) begin
            n_fail++;
            $display("FAIL lw_after_sb: got rdata=%08h lat=%0d want 80AA7F01 2", rd, lat);
        end
    endtask

    task automatic test_store_word();
        int lat, wc;
        logic [31:0] rd;
        logic err, va;
        wc = wr_count;
        issue(1'b1, 3'b010, 32'h104, 32'hDEADBEEF, lat, rd, err, va);
        n_cmp++;
        if (lat != 2 || err !== 1'b0 || rd !== 32'd0) begin
            n_fail++;
            $display("FAIL sw_resp: got lat=%0d err=%0b rdata=%08h want 2 0 00000000", lat, err, rd);
        end
        n_cmp++;
        if (wr_count != wc + 1 || last_wr_addr !== 32'h104 || last_wr_data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL sw_write: got n=%0d addr=%08h data=%08h want 1 00000104 DEADBEEF",
                     wr_count - wc, last_wr_addr, last_wr_data);
        end
        issue(1'b0, 3'b010, 32'h104, 32'd0, lat, rd, err, va);
        n_cmp++;
        if (rd !== 32'hDEADBEEF || lat != 2) begin
            n_fail++;
            $display("FAIL lw_104: got rdata=%08h lat=%0d want DEADBEEF 2", rd, lat);
        end
        wc = wr_count;
        issue(1'b1, 3'b001, 32'h106, 32'hFFFF5566, lat, rd, err, va);
        n_cmp++;
        if (lat != 3 || wr_count != wc + 1 || last_wr_data !== 32'hDEAD5566) begin
            n_fail++;
            $display("FAIL sh_106: got lat=%0d n=%0d data=%08h want 3 1 DEAD5566",
                     lat, wr_count - wc, last_wr_data);
        end
    endtask

    task automatic test_errors();
        int lat, wc;
        logic [31:0] rd;
        logic err, va;
        wc = wr_count;
        issue(1'b0, 3'b010, 32'h102, 32'd0, lat, rd, err, va);
        n_cmp++;
        if (lat != 1 || err !== 1'b1 || rd !== 32'd0) begin
            n_fail++;
            $display("FAIL lw_misaligned: got lat=%0d err=%0b rdata=%08h want 1 1 00000000", lat, err, rd);
        end
        issue(1'b1, 3'b001, 32'h101, 32'h0000BEEF, lat, rd, err, va);
        n_cmp++;
        if (lat != 1 || err !== 1'b1 || rd !== 32'd0) begin
            n_fail++;
            $display("FAIL sh_misaligned: got lat=%0d err=%0b rdata=%08h want 1 1 00000000", lat, err, rd);
        end
        issue(1'b1, 3'b100, 32'h108, 32'h55555555, lat, rd, err, va);
        n_cmp++;
        if (lat != 1 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL store_bad_f3: got lat=%0d err=%0b want 1 1", lat, err);
        end
        n_cmp++;
        if (wr_count != wc) begin
            n_fail++;
            $display("FAIL errors_no_write: got %0d writes want 0", wr_count - wc);
        end
    endtask

    task automatic test_back_to_back();
        int wc;
        wc = wr_count;
        @(negedge clk_i);
        req_valid_i  = 1'b1;
        req_we_i     = 1'b0;
        req_funct3_i = 3'b010;
        req_addr_i   = 32'h104;
        req_wdata_i  = 32'd0;
        @(posedge clk_i);
        #1;
        // Held while busy: must be ignored until the unit is back in IDLE.
        req_we_i    = 1'b1;
        req_addr_i  = 32'h10C;
        req_wdata_i = 32'h12345678;
        repeat (2) @(negedge clk_i);
        $display("txn b2b lw addr=00000104 -> valid=%0b rdata=%08h", resp_valid_o, resp_rdata_o);
        n_cmp++;
        if (resp_valid_o !== 1'b1 || resp_rdata_o !== 32'hDEAD5566 || wr_count != wc) begin
            n_fail++;
            $display("FAIL b2b_load: got valid=%0b rdata=%08h writes=%0d want 1 DEAD5566 0",
                     resp_valid_o, resp_rdata_o, wr_count - wc);
        end
        @(negedge clk_i);
        n_cmp++;
        if (req_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready: got %0b want 1", req_ready_o);
        end
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        $display("txn b2b sw addr=0000010C wdata=12345678 -> valid=%0b", resp_valid_o);
        n_cmp++;
        if (resp_valid_o !== 1'b1 || wr_count != wc + 1 || last_wr_addr !== 32'h10C ||
            last_wr_data !== 32'h12345678) begin
            n_fail++;
            $display("FAIL b2b_store: got valid=%0b n=%0d addr=%08h data=%08h want 1 1 0000010C 12345678",
                     resp_valid_o, wr_count - wc, last_wr_addr, last_wr_data);
        end
        @(negedge clk_i);
    endtask

    task automatic test_reset_during_write();
        int wc, lat;
        logic seen_valid, seen_we, err, va;
        logic [31:0] rd;
        wc = wr_count;
        seen_valid = 1'b0;
        seen_we    = 1'b0;
        @(negedge clk_i);
        req_valid_i  = 1'b1;
        req_we_i     = 1'b1;
        req_funct3_i = 3'b000;
        req_addr_i   = 32'h108;
        req_wdata_i  = 32'h000000AA;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        n_cmp++;
        if (mem_write_enable_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_in_write_state: got we=%0b want 1 before reset", mem_write_enable_o);
        end
        rst_ni = 1'b0;
        #1;
        n_cmp++;
        if (mem_write_enable_o !== 1'b0 || mem_address_o !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_async: got we=%0b addr=%08h want 0 00000000",
                     mem_write_enable_o, mem_address_o);
        end
        repeat (2) begin
            @(negedge clk_i);
            seen_valid |= resp_valid_o;
        end
        rst_ni = 1'b1;
        #1;
        n_cmp++;
        if (req_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_release_ready: got %0b want 1", req_ready_o);
        end
        repeat (3) begin
            @(negedge clk_i);
            seen_valid |= resp_valid_o;
            seen_we    |= mem_write_enable_o;
        end
        $display("txn sb addr=00000108 aborted by reset -> writes=%0d valid_seen=%0b",
                 wr_count - wc, seen_valid);
        n_cmp++;
        if (wr_count != wc || seen_valid !== 1'b0 || seen_we !== 1'b0 || mem[8'h42] !== 32'h11223344) begin
            n_fail++;
            $display("FAIL rst_abort: got writes=%0d valid_seen=%0b we_seen=%0b mem=%08h want 0 0 0 11223344",
                     wr_count - wc, seen_valid, seen_we, mem[8'h42]);
        end
        issue(1'b0, 3'b010, 32'h108, 32'd0, lat, rd, err, va);
        n_cmp++;
        if (rd !== 32'h11223344 || lat != 2 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_after_rst: got rdata=%08h lat=%0d err=%0b want 11223344 2 0", rd, lat, err);
        end
    endtask

    initial begin
        req_valid_i  = 1'b0;
        req_we_i     = 1'b0;
        req_funct3_i = 3'd0;
        req_addr_i   = 32'd0;
        req_wdata_i  = 32'd0;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[8'h40] = 32'h80FF7F01;
        mem[8'h42] = 32'h11223344;

        test_reset();
        test_loads();
        test_store_byte();
        test_store_word();
        test_errors();
        test_back_to_back();
        test_reset_during_write();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
